// File: rtl/move_controller.sv
// Connect4 (4x4) move controller: turns column selections into animated piece
// drops, owns the board/ownership vectors and alternates turns until a result.
module move_controller #(
  parameter int FALL_TICKS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  col_sel,
  input  logic        drop,
  input  logic        new_game,
  input  logic [1:0]  game_status,
  output logic [15:0] game_board,
  output logic [15:0] player_cells,
  output logic        current_player,
  output logic        anim_valid,
  output logic [1:0]  anim_row,
  output logic [1:0]  anim_col,
  output logic        col_full_err,
  output logic [4:0]  move_count,
  output logic        busy,
  output logic [2:0]  fsm_state
);

  // Handshake: a move request is the rising edge of drop while IDLE; there is
  // no ready signal, edges seen in any other state are dropped, never queued.

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FALL   = 3'd1,
    COMMIT = 3'd2,
    SETTLE = 3'd3,
    OVER   = 3'd4
  } state_t;

  localparam logic [7:0] TICK_LAST = 8'(FALL_TICKS - 1);

  state_t      state, state_n;
  logic [15:0] board_n, cells_n;
  logic        player_n, valid_n, err_n;
  logic [1:0]  row_n, col_n, row_dn;
  logic [4:0]  count_n;
  logic [7:0]  tick, tick_n;
  logic        drop_q, drop_edge;
  logic [3:0]  cell_idx, below_idx, top_idx;

  assign drop_edge = drop & ~drop_q;
  assign row_dn    = anim_row - 2'd1;
  assign cell_idx  = {anim_row, anim_col};
  assign below_idx = {row_dn, anim_col};
  assign top_idx   = {2'b11, col_sel};
  assign busy      = (state == FALL) || (state == COMMIT) || (state == SETTLE);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      game_board     <= 16'd0;
      player_cells   <= 16'd0;
      current_player <= 1'b0;
      move_count     <= 5'd0;
      anim_valid     <= 1'b0;
      anim_row       <= 2'd0;
      anim_col       <= 2'd0;
      col_full_err   <= 1'b0;
      tick           <= 8'd0;
      drop_q         <= 1'b0;
    end else begin
      state          <= state_n;
      game_board     <= board_n;
      player_cells   <= cells_n;
      current_player <= player_n;
      move_count     <= count_n;
      anim_valid     <= valid_n;
      anim_row       <= row_n;
      anim_col       <= col_n;
      col_full_err   <= err_n;
      tick           <= tick_n;
      drop_q         <= drop;
    end
  end

  always_comb begin
    state_n  = state;
    board_n  = game_board;
    cells_n  = player_cells;
    player_n = current_player;
    count_n  = move_count;
    valid_n  = anim_valid;
    row_n    = anim_row;
    col_n    = anim_col;
    tick_n   = tick;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        if (new_game) begin
          board_n  = 16'd0;
          cells_n  = 16'd0;
          count_n  = 5'd0;
          player_n = 1'b0;
        end else if (drop_edge && game_status == 2'b00 && game_board[top_idx]) begin
          err_n = 1'b1;
        end else if (drop_edge && game_status == 2'b00) begin
          col_n   = col_sel;
          row_n   = 2'd3;
          tick_n  = 8'd0;
          valid_n = 1'b1;
          state_n = FALL;
        end else if (game_status != 2'b00) begin
          state_n = OVER;
        end
      end
      FALL: begin
        if (tick == TICK_LAST) begin
          tick_n = 8'd0;
          // Keep falling only while the cell underneath is still empty.
          if (anim_row != 2'd0 && !game_board[below_idx]) row_n = row_dn;
          else state_n = COMMIT;
        end else begin
          tick_n = tick + 8'd1;
        end
      end
      COMMIT: begin
        board_n[cell_idx] = 1'b1;
        cells_n[cell_idx] = current_player;
        count_n = (move_count == 5'd16) ? move_count : move_count + 5'd1;
        valid_n = 1'b0;
        state_n = SETTLE;
      end
      SETTLE: begin
        if (game_status != 2'b00) begin
          state_n = OVER;
        end else begin
          player_n = ~current_player;
          state_n  = IDLE;
        end
      end
      OVER: begin
        if (new_game) begin
          board_n  = 16'd0;
          cells_n  = 16'd0;
          count_n  = 5'd0;
          player_n = 1'b0;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: directed scenarios plus random games, checked
// against a column-height model of the Connect4 board.
module tb_move_controller;

  localparam int FT = 4;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_OVER = 3'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  col_sel;
  logic        drop;
  logic        new_game;
  logic [1:0]  game_status;
  logic [15:0] game_board;
  logic [15:0] player_cells;
  logic        current_player;
  logic        anim_valid;
  logic [1:0]  anim_row;
  logic [1:0]  anim_col;
  logic        col_full_err;
  logic [4:0]  move_count;
  logic        busy;
  logic [2:0]  fsm_state;

  move_controller #(.FALL_TICKS(FT)) dut (
    .clk(clk), .reset(reset), .col_sel(col_sel), .drop(drop),
    .new_game(new_game), .game_status(game_status),
    .game_board(game_board), .player_cells(player_cells),
    .current_player(current_player), .anim_valid(anim_valid),
    .anim_row(anim_row), .anim_col(anim_col), .col_full_err(col_full_err),
    .move_count(move_count), .busy(busy), .fsm_state(fsm_state)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  int check_cnt = 0;
  int pass_cnt  = 0;

  // Reference model: per-column stack heights plus board/owner images.
  int          height[4];
  logic [15:0] m_board, m_cells;
  logic        m_player;
  int          m_count;
  logic [15:0] exp_q[$];

  task automatic model_clear();
    for (int i = 0; i < 4; i++) height[i] = 0;
    m_board  = 16'd0;
    m_cells  = 16'd0;
    m_player = 1'b0;
    m_count  = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; drop = 1'b0; new_game = 1'b0; game_status = 2'b00; col_sel = 2'd0;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  // Driver: one full move into column c; game status gs is presented during SETTLE.
  task automatic play(input logic [1:0] c, input logic [1:0] gs, input bit chk_anim);
    int r, j, lat, exp_row;
    logic [3:0]  bit_i;
    logic [15:0] expb, expc;
    r     = height[c];
    bit_i = 4'(r * 4 + int'(c));
    lat   = 1 + (4 - r) * FT;
    expb  = m_board | (16'd1 << bit_i);
    expc  = m_cells | ({15'd0, m_player} << bit_i);
    exp_q.push_back(expb);
    @(negedge clk);
    col_sel = c; drop = 1'b1;
    @(negedge clk);
    drop = 1'b0;
    j = 0;
    while (game_board[bit_i] !== 1'b1 && j < 200) begin
      if (chk_anim) begin
        exp_row = 3 - j / FT;
        if (exp_row < r) exp_row = r;
        check_cnt++;
        if (anim_valid !== 1'b1 || anim_row !== 2'(exp_row) || anim_col !== c || busy !== 1'b1)
          $display("FAIL anim j=%0d: got v=%b row=%0d col=%0d busy=%b exp v=1 row=%0d col=%0d busy=1",
                   j, anim_valid, anim_row, anim_col, busy, exp_row, c);
        else pass_cnt++;
      end
      @(negedge clk);
      j++;
    end
    game_status = gs;
    check_cnt++;
    if (j !== lat) $display("FAIL latency col=%0d: got %0d exp %0d", c, j, lat);
    else pass_cnt++;
    check_cnt++;
    if (game_board !== exp_q[0]) $display("FAIL board_commit: got %h exp %h", game_board, exp_q[0]);
    else pass_cnt++;
    void'(exp_q.pop_front());
    check_cnt++;
    if (player_cells !== expc) $display("FAIL cells_commit: got %h exp %h", player_cells, expc);
    else pass_cnt++;
    check_cnt++;
    if (anim_valid !== 1'b0) $display("FAIL anim_valid_after_commit: got %b exp 0", anim_valid);
    else pass_cnt++;
    height[c] = height[c] + 1;
    m_board = expb;
    m_cells = expc;
    m_count++;
    if (gs == 2'b00) m_player = ~m_player;
    @(negedge clk);
    check_cnt++;
    if (fsm_state !== ((gs == 2'b00) ? ST_IDLE : ST_OVER))
      $display("FAIL state_after_settle: got %0d exp %0d", fsm_state, (gs == 2'b00) ? ST_IDLE : ST_OVER);
    else pass_cnt++;
    check_cnt++;
    if (current_player !== m_player || move_count !== 5'(m_count) || busy !== 1'b0)
      $display("FAIL turn_state: got p=%b cnt=%0d busy=%b exp p=%b cnt=%0d busy=0",
               current_player, move_count, busy, m_player, m_count);
    else pass_cnt++;
    check_cnt++;
    if ((player_cells & ~game_board) !== 16'd0)
      $display("FAIL invariant: got cells=%h board=%h exp no owner on empty cell", player_cells, game_board);
    else pass_cnt++;
  endtask

  // Driver: drop into a full column; expect a single error pulse and no change.
  task automatic try_full(input logic [1:0] c);
    @(negedge clk);
    col_sel = c; drop = 1'b1;
    @(negedge clk);
    drop = 1'b0;
    check_cnt++;
    if (col_full_err !== 1'b1) $display("FAIL col_full_pulse: got %b exp 1", col_full_err);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if (col_full_err !== 1'b0) $display("FAIL col_full_once: got %b exp 0", col_full_err);
    else pass_cnt++;
    check_cnt++;
    if (game_board !== m_board || player_cells !== m_cells || move_count !== 5'(m_count) ||
        current_player !== m_player || fsm_state !== ST_IDLE)
      $display("FAIL col_full_nochange: got b=%h c=%h n=%0d p=%b s=%0d exp b=%h c=%h n=%0d p=%b s=0",
               game_board, player_cells, move_count, current_player, fsm_state,
               m_board, m_cells, m_count, m_player);
    else pass_cnt++;
  endtask

  task automatic do_new_game();
    @(negedge clk);
    new_game = 1'b1; game_status = 2'b00;
    @(negedge clk);
    new_game = 1'b0;
    model_clear();
    check_cnt++;
    if (game_board !== 16'd0 || player_cells !== 16'd0 || move_count !== 5'd0 ||
        current_player !== 1'b0 || fsm_state !== ST_IDLE)
      $display("FAIL new_game_clear: got b=%h c=%h n=%0d p=%b s=%0d exp all zero",
               game_board, player_cells, move_count, current_player, fsm_state);
    else pass_cnt++;
  endtask

  task automatic check_reset_values(input string tag);
    check_cnt++;
    if (game_board !== 16'd0 || player_cells !== 16'd0 || current_player !== 1'b0 ||
        move_count !== 5'd0 || anim_valid !== 1'b0 || anim_row !== 2'd0 || anim_col !== 2'd0 ||
        col_full_err !== 1'b0 || busy !== 1'b0 || fsm_state !== ST_IDLE)
      $display("FAIL %s: got b=%h c=%h p=%b n=%0d v=%b r=%0d c=%0d e=%b busy=%b s=%0d exp all zero",
               tag, game_board, player_cells, current_player, move_count, anim_valid,
               anim_row, anim_col, col_full_err, busy, fsm_state);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1; drop = 1'b0; new_game = 1'b0; game_status = 2'b00; col_sel = 2'd0;
    repeat (2) @(negedge clk);
    check_reset_values("reset_state");
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_first_drop();
    play(2'd2, 2'b00, 1'b1);
    check_cnt++;
    if (game_board !== 16'h0004 || player_cells !== 16'h0000 || current_player !== 1'b1)
      $display("FAIL first_drop: got b=%h c=%h p=%b exp b=0004 c=0000 p=1",
               game_board, player_cells, current_player);
    else pass_cnt++;
  endtask

  task automatic test_second_drop();
    play(2'd2, 2'b00, 1'b1);
    check_cnt++;
    if (game_board !== 16'h0044 || player_cells !== 16'h0040 || current_player !== 1'b0)
      $display("FAIL second_drop: got b=%h c=%h p=%b exp b=0044 c=0040 p=0",
               game_board, player_cells, current_player);
    else pass_cnt++;
  endtask

  task automatic test_col_full();
    apply_reset();
    for (int i = 0; i < 4; i++) play(2'd0, 2'b00, 1'b0);
    check_cnt++;
    if (game_board !== 16'h1111 || player_cells !== 16'h1010 || move_count !== 5'd4)
      $display("FAIL fill_col0: got b=%h c=%h n=%0d exp b=1111 c=1010 n=4",
               game_board, player_cells, move_count);
    else pass_cnt++;
    try_full(2'd0);
  endtask

  task automatic test_hold_drop();
    logic [1:0]  c;
    logic [15:0] expb;
    c = 2'($urandom_range(1, 3));
    expb = m_board | (16'd1 << (height[c] * 4 + int'(c)));
    @(negedge clk);
    col_sel = c; drop = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 3) drop = 1'b0;
      if (i == 4) begin drop = 1'b1; col_sel = 2'($urandom_range(0, 3)); end
    end
    drop = 1'b0;
    repeat (2) @(negedge clk);
    height[c] = height[c] + 1;
    m_cells = m_cells | ({15'd0, m_player} << (height[c] * 4 - 4 + int'(c)));
    m_board = expb;
    m_count++;
    m_player = ~m_player;
    check_cnt++;
    if (move_count !== 5'(m_count) || game_board !== m_board || player_cells !== m_cells ||
        current_player !== m_player || fsm_state !== ST_IDLE)
      $display("FAIL hold_drop: got n=%0d b=%h c=%h p=%b s=%0d exp n=%0d b=%h c=%h p=%b s=0",
               move_count, game_board, player_cells, current_player, fsm_state,
               m_count, m_board, m_cells, m_player);
    else pass_cnt++;
  endtask

  task automatic test_game_over();
    apply_reset();
    play(2'($urandom_range(0, 3)), 2'b01, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      col_sel = 2'($urandom_range(0, 3)); drop = 1'b1;
      @(negedge clk);
      drop = 1'b0;
    end
    repeat (2) @(negedge clk);
    check_cnt++;
    if (fsm_state !== ST_OVER || game_board !== m_board || move_count !== 5'd1 ||
        current_player !== 1'b0 || busy !== 1'b0 || anim_valid !== 1'b0)
      $display("FAIL over_frozen: got s=%0d b=%h n=%0d p=%b busy=%b v=%b exp s=4 b=%h n=1 p=0 busy=0 v=0",
               fsm_state, game_board, move_count, current_player, busy, anim_valid, m_board);
    else pass_cnt++;
    do_new_game();
  endtask

  task automatic test_reset_mid_fall();
    int j;
    apply_reset();
    play(2'd1, 2'b00, 1'b0);
    @(negedge clk);
    col_sel = 2'd3; drop = 1'b1;
    @(negedge clk);
    drop = 1'b0;
    j = 0;
    while (!(anim_valid === 1'b1 && anim_row === 2'd2) && j < 50) begin
      @(negedge clk);
      j++;
    end
    check_cnt++;
    if (j >= 50) $display("FAIL reach_row2: got timeout exp anim_row=2 within 50 cycles");
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("reset_mid_fall");
    reset = 1'b0;
    model_clear();
    play(2'd3, 2'b00, 1'b1);
    check_cnt++;
    if (game_board !== 16'h0008 || player_cells !== 16'h0000 || move_count !== 5'd1)
      $display("FAIL fresh_after_reset: got b=%h c=%h n=%0d exp b=0008 c=0000 n=1",
               game_board, player_cells, move_count);
    else pass_cnt++;
  endtask

  task automatic test_random_games();
    logic [1:0] c;
    apply_reset();
    for (int n = 0; n < 40; n++) begin
      if (m_count == 16 || $urandom_range(0, 19) == 0) begin
        do_new_game();
      end else begin
        c = 2'($urandom_range(0, 3));
        if (height[c] == 4) try_full(c);
        else play(c, 2'b00, 1'b0);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_first_drop();
    test_second_drop();
    test_col_full();
    test_hold_drop();
    test_game_over();
    test_reset_mid_fall();
    test_random_games();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/move_controller.md
Name: move_controller

Overview:
- Upstream stage of the win detector in the 4x4 Connect4 datapath.
- Turns player column selections into piece drops, with a timed falling animation.
- Maintains the authoritative game_board / player_cells vectors that the win detector consumes.
- Alternates turns, rejects drops into full columns, and freezes play once the detector reports a result.

Parameters:
- FALL_TICKS, 4: clock cycles a falling piece dwells on each row; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- col_sel  in  2  column to drop into (0..3)
- drop  in  1  level from debounced button; a rising edge requests a move
- new_game  in  1  level; while high in IDLE or OVER, clears the board
- game_status  in  2  from win detector: 00 playing, 01 P1 wins, 10 P2 wins, 11 tie
- game_board  out  16  occupied cells; bit = row*4 + col, row 0 = bottom
- player_cells  out  16  owner of each occupied cell: 1 = P2, 0 = P1; 0 where unoccupied
- current_player  out  1  0 = P1 to move, 1 = P2 to move
- anim_valid  out  1  high while a piece is falling
- anim_row  out  2  row of the falling piece (valid when anim_valid)
- anim_col  out  2  column of the falling piece (valid when anim_valid)
- col_full_err  out  1  one-cycle pulse when a drop targets a full column
- move_count  out  5  committed pieces, 0..16
- busy  out  1  high in any state other than IDLE and OVER

Behaviour:
- Reset, synchronous: state = IDLE, game_board = 0, player_cells = 0, current_player = 0, move_count = 0, anim_valid = 0, anim_row = 0, anim_col = 0, col_full_err = 0, drop_q = 0. Reset overrides everything, including mid-fall and the OVER state.
- Edge detect: drop_q <= drop every cycle; drop_edge = drop & ~drop_q. An edge is acted on only in IDLE. Edges in any other state are discarded, not queued.
- States: IDLE, FALL, COMMIT, SETTLE, OVER.
- IDLE, priority order:
  - new_game high: clear board, player_cells, move_count; current_player = 0; stay IDLE.
  - Else, drop_edge and game_status == 00 and game_board[12+col_sel] == 1 (column full): col_full_err = 1 for exactly one cycle; stay IDLE; no state changes.
  - Else, drop_edge and game_status == 00: latch col = col_sel; row = 3; tick = 0; anim_valid = 1; go to FALL.
  - Else, game_status != 00: go to OVER.
- FALL: tick increments each cycle. When tick == FALL_TICKS-1:
  - tick = 0.
  - If row > 0 and game_board[(row-1)*4 + col] == 0: row = row - 1; stay in FALL.
  - Else go to COMMIT.
  - anim_row tracks row throughout.
- COMMIT, one cycle:
  - game_board[row*4+col] <= 1; player_cells[row*4+col] <= current_player.
  - move_count += 1; anim_valid <= 0; go to SETTLE.
- SETTLE, one cycle: lets the detector observe the new board.
  - game_status != 00: go to OVER; current_player unchanged.
  - Else: toggle current_player; go to IDLE.
- OVER: all drops ignored. new_game high: clear exactly as in IDLE and go to IDLE. The detector returns to 00 itself when the board is 0.
- Latency: the drop edge is sampled at edge E. The board bit is visible after edge E + 1 + (4 - r_final)*FALL_TICKS, where r_final is the landing row.
- Width rules:
  - move_count saturates at 16; it cannot exceed 16 because a full board blocks drops.
  - tick counter is 8 bits wide.
- Invariant: player_cells is never 1 where game_board is 0.
- busy = 1 in FALL, COMMIT and SETTLE.

Test Plan:
- Reset, then drop col 2 on an empty board, FALL_TICKS = 4 -> game_board = 0x0004, player_cells = 0, bit set 17 cycles after the edge sample; anim_row sequence 3,2,1,0 with 4 cycles each; current_player becomes 1.
- Second drop on col 2 -> lands at row 1; game_board = 0x0044, player_cells = 0x0040, current_player = 0.
- Fill col 0 with 4 drops, then a fifth drop on col 0 -> col_full_err high exactly 1 cycle; board, player and move_count unchanged at 0x1111 / 4.
- Hold drop high for 100 cycles and pulse it during FALL -> exactly one move committed; move_count increments by 1 only.
- Model the detector returning 01 one cycle after COMMIT -> state OVER, current_player frozen; further drops ignored; new_game -> board = 0, move_count = 0, current_player = 0, state IDLE.
- Assert reset during FALL (row = 2) -> next cycle all outputs at reset values; a subsequent drop behaves as on a fresh board.
